// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared button index constants and hold FSM encoding
package btn_debounce_pkg;

    localparam int BTN_L = 4;
    localparam int BTN_R = 3;
    localparam int BTN_U = 2;
    localparam int BTN_D = 1;
    localparam int BTN_C = 0;

    localparam int BTN_COUNT = BTN_L - BTN_C + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button pads in, debounced levels and pulses out
interface btn_debounce_if;
    import btn_debounce_pkg::*;

    logic [BTN_COUNT-1:0] btn_in;
    logic [BTN_COUNT-1:0] btn_level;
    logic [BTN_COUNT-1:0] btn_press;
    logic [BTN_COUNT-1:0] btn_release;
    logic [BTN_COUNT-1:0] btn_key;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_key
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_key
    );

endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchronizer, debounce counter, edge pulses, hold/repeat FSM
module btn_channel
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic key
);

    localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_LAST   = 32'(REPEAT_PERIOD - 1);

    logic        sync1;
    logic        sync2;
    logic [31:0] db_cnt;
    logic [31:0] timer;
    hold_state_t state;

    logic accept;
    logic rise;
    logic fall;

    // A level change is accepted on the edge the mismatch run reaches DEBOUNCE_CYCLES.
    always_comb begin
        accept = (sync2 != level) && (db_cnt == DB_LAST);
        rise   = accept && !level;
        fall   = accept && level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            db_cnt        <= '0;
            timer         <= '0;
            state         <= IDLE;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            key           <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;

            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 32'd1;
            end

            press_pulse   <= rise;
            release_pulse <= fall;
            key           <= rise;

            // Release wins over a coinciding repeat so no pulse lands in the release cycle.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= DELAY;
                        timer <= '0;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == DELAY_LAST) begin
                        state <= REPEAT;
                        timer <= '0;
                        key   <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == RPT_LAST) begin
                        timer <= '0;
                        key   <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - five independent debounced button channels with auto-repeat
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);

    logic [BTN_COUNT-1:0] level;
    logic [BTN_COUNT-1:0] press;
    logic [BTN_COUNT-1:0] release_p;
    logic [BTN_COUNT-1:0] key;

    for (genvar i = BTN_C; i <= BTN_L; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .raw           (bus.btn_in[i]),
            .level         (level[i]),
            .press_pulse   (press[i]),
            .release_pulse (release_p[i]),
            .key           (key[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = release_p;
    assign bus.btn_key     = key;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed bench for btn_debounce with short debounce/repeat timing
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    btn_debounce_if bus ();

    btn_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int c, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input int c);
        check({tag, "_level"},   c, bus.btn_level,   5'b0);
        check({tag, "_press"},   c, bus.btn_press,   5'b0);
        check({tag, "_release"}, c, bus.btn_release, 5'b0);
        check({tag, "_key"},     c, bus.btn_key,     5'b0);
    endtask

    // Leaves the bench mid-cycle 0 with reset released and all pads low.
    task automatic do_reset();
        rst = 1'b1;
        bus.btn_in = 5'b0;
        step();
        step();
        check_all_zero("reset", 0);
        rst = 1'b0;
    endtask

    initial begin
        // Held press: accept at 6, repeats at 26, 34, 42
        do_reset();
        bus.btn_in = 5'b00001;
        for (int c = 1; c <= 45; c++) begin
            step();
            check("hold_level", c, bus.btn_level, (c >= 6) ? 5'b00001 : 5'b0);
            check("hold_press", c, bus.btn_press, (c == 6) ? 5'b00001 : 5'b0);
            check("hold_key",   c, bus.btn_key,
                  (c == 6 || c == 26 || c == 34 || c == 42) ? 5'b00001 : 5'b0);
            check("hold_release", c, bus.btn_release, 5'b0);
        end

        // Short 3-cycle pulse on BTNL is rejected
        do_reset();
        bus.btn_in = 5'b10000;
        for (int c = 1; c <= 15; c++) begin
            step();
            check_all_zero("short", c);
            if (c == 2) bus.btn_in = 5'b0;
        end

        // Press at 6, pin released at 15, release pulse at 21, no repeats
        do_reset();
        bus.btn_in = 5'b00001;
        for (int c = 1; c <= 50; c++) begin
            step();
            check("rel_level",   c, bus.btn_level,   (c >= 6 && c < 21) ? 5'b00001 : 5'b0);
            check("rel_press",   c, bus.btn_press,   (c == 6) ? 5'b00001 : 5'b0);
            check("rel_release", c, bus.btn_release, (c == 21) ? 5'b00001 : 5'b0);
            check("rel_key",     c, bus.btn_key,     (c == 6) ? 5'b00001 : 5'b0);
            if (c == 15) bus.btn_in = 5'b0;
        end

        // BTNR and BTND together
        do_reset();
        bus.btn_in = 5'b01010;
        for (int c = 1; c <= 36; c++) begin
            step();
            check("dual_press", c, bus.btn_press, (c == 6) ? 5'b01010 : 5'b0);
            check("dual_key",   c, bus.btn_key,
                  (c == 6 || c == 26 || c == 34) ? 5'b01010 : 5'b0);
        end

        // Reset at cycle 30 while repeating; held button re-accepted at 37
        do_reset();
        bus.btn_in = 5'b00001;
        for (int c = 1; c <= 45; c++) begin
            step();
            if (c == 31) begin
                check_all_zero("midrst", c);
            end
            check("midrst_level", c, bus.btn_level,
                  ((c >= 6 && c < 31) || c >= 37) ? 5'b00001 : 5'b0);
            check("midrst_press", c, bus.btn_press, (c == 6 || c == 37) ? 5'b00001 : 5'b0);
            check("midrst_key",   c, bus.btn_key,
                  (c == 6 || c == 26 || c == 37) ? 5'b00001 : 5'b0);
            if (c == 30) rst = 1'b1;
            if (c == 31) rst = 1'b0;
        end

        // One-cycle low glitch during hold is ignored
        do_reset();
        bus.btn_in = 5'b00001;
        for (int c = 1; c <= 25; c++) begin
            step();
            check("glitch_level",   c, bus.btn_level,   (c >= 6) ? 5'b00001 : 5'b0);
            check("glitch_press",   c, bus.btn_press,   (c == 6) ? 5'b00001 : 5'b0);
            check("glitch_release", c, bus.btn_release, 5'b0);
            if (c == 10) bus.btn_in = 5'b0;
            if (c == 11) bus.btn_in = 5'b00001;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, meaning the number of hold cycles from the press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, meaning the number of cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock (clk_100mhz at the top level); all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn_in, input, 5 bits: raw asynchronous pad inputs {BTNL,BTNR,BTNU,BTND,BTNC}, bits 4..0.
REQ-007 SHALL have port btn_level, output, 5 bits: debounced button levels.
REQ-008 SHALL have port btn_press, output, 5 bits: one-cycle pulse per bit on an accepted rising level.
REQ-009 SHALL have port btn_release, output, 5 bits: one-cycle pulse per bit on an accepted falling level.
REQ-010 SHALL have port btn_key, output, 5 bits: press OR auto-repeat pulses; this is the input consumed by the button-entry stage.

Function
REQ-011 SHALL pass each btn_in bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep a per-bit mismatch counter: it increments while the synchronized input differs from btn_level and clears to 0 on any cycle where they are equal.
REQ-013 SHALL toggle btn_level on the edge where the mismatch count reaches DEBOUNCE_CYCLES, and clear the counter on that same edge; pin-to-level latency is DEBOUNCE_CYCLES+2 cycles.
REQ-014 SHALL ignore input pulses or glitches shorter than DEBOUNCE_CYCLES synchronized cycles: no level change and no pulses.
REQ-015 SHALL assert btn_press or btn_release for exactly the first cycle in which the new btn_level value is visible.
REQ-016 SHALL run a per-bit hold FSM with the states below.
- IDLE: on press, go to DELAY and clear the timer.
- DELAY: the timer counts cycles; when it reaches REPEAT_DELAY, emit a repeat pulse, go to REPEAT and clear the timer.
- REPEAT: emit a repeat pulse every REPEAT_PERIOD cycles.
REQ-017 SHALL return the FSM to IDLE and clear its timer on a release from any state; no repeat pulse is emitted in the release cycle.
REQ-018 SHALL drive btn_key as press OR repeat per bit, always exactly one cycle wide.
REQ-019 SHALL process the five bits fully independently, so any combination of bits may pulse in the same cycle.
REQ-020 SHALL use 32-bit counters and requires all parameters to be at least 1; values outside this range are unsupported.

Reset
REQ-021 SHALL, on any clk edge with rst=1, clear the synchronizers, counters and timers, set every FSM to IDLE, and drive all outputs to 0, including mid-debounce or mid-repeat.
REQ-022 SHALL treat a button held through reset as a new press after release of reset: btn_level rises and btn_press pulses DEBOUNCE_CYCLES+2 cycles later.

Structure
REQ-023 SHALL take the button bit-index constants (BTN_L=4 … BTN_C=0) and the FSM state encodings (IDLE, DELAY, REPEAT) from the shared project constants package.
REQ-024 SHALL implement one sub-module, btn_channel, covering the synchronizer, debounce counter, edge pulses and hold FSM for a single bit, instantiated five times.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-025 SHALL verify: btn_in[0] rises at cycle 0 and is held -> btn_level[0]=1 and btn_press[0]=btn_key[0]=1 at cycle 6 only; btn_key[0] pulses again at cycles 26, 34 and 42.
REQ-026 SHALL verify: btn_in[4] driven high for 3 cycles, then low -> btn_level, btn_press and btn_key stay 0 throughout.
REQ-027 SHALL verify: a press accepted at cycle 6, then release of the pin at cycle 15 -> btn_release[0] pulses at cycle 21 and no repeat pulse occurs afterward.
REQ-028 SHALL verify: btn_in[3] and btn_in[1] rise in the same cycle -> both press bits pulse in the same cycle with identical repeat timing.
REQ-029 SHALL verify: rst=1 for one cycle at cycle 30 while a button is held in REPEAT -> all outputs are 0 at cycle 31 and btn_press pulses again at cycle 37.
REQ-030 SHALL verify: a 1-cycle glitch low during a 10-cycle hold after acceptance -> btn_level stays 1 with no release or press pulses.
